core_rrv_wb: RTL

Write-back stage of the rrv core: the producer side of the register-file write port. Takes the Q104H instruction (ALU result, PC+4 or data-memory load response), aligns and extends load data, and drives the Q105H write triplet (RegWrEnQ105H, RegDstQ105H, RegWrDataQ105H) into the register file. A two-state FSM stalls the pipeline through ReadyQ104H when a load response is late, so each instruction produces exactly one register write.

---
 rtl/core_rrv_pkg.sv | 29 ++
 rtl/core_rrv_wb_ld_align.sv | 29 ++
 rtl/core_rrv_wb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/core_rrv_pkg.sv
// Shared types for the rrv write-back stage: control bundle, write-back
// select, FSM state encoding and load byte-enable patterns.
package core_rrv_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } t_wb_sel;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_RSP = 1'b1
  } t_wb_state;

  typedef struct packed {
    logic       ValidQ104H;
    logic       RegWrEnQ104H;
    logic [4:0] RegDstQ104H;
    t_wb_sel    WbSelQ104H;
    logic [3:0] ByteEnQ104H;
    logic       SignExtQ104H;
  } t_ctrl_wb;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/core_rrv_wb_ld_align.sv
// Load data alignment: picks the addressed byte/half out of the raw word and
// sign- or zero-extends it. Unknown byte-enable patterns pass the word through.
module core_rrv_wb_ld_align
  import core_rrv_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [3:0]  byte_en,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] byte_shift;
  logic [15:0] half_sel;

  assign byte_shift = data >> {offset, 3'b000};
  assign half_sel   = offset[1] ? data[31:16] : data[15:0];

  always_comb begin
    result = data;
    case (byte_en)
      BE_BYTE: result = {{24{sign_ext & byte_shift[7]}}, byte_shift[7:0]};
      BE_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      BE_WORD: result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/core_rrv_wb.sv
// rrv write-back stage: Q104H -> Q105H register-file write port with a
// two-state load-wait FSM. Optional load timeout under CORE_RRV_WB_TIMEOUT_EN.
module core_rrv_wb
  import core_rrv_pkg::*;
#(
  parameter int WB_TIMEOUT_CYC = 64
) (
  input  logic        Clock,
  input  logic        Rst,
  input  t_ctrl_wb    Ctrl,
  input  logic [31:0] AluResultQ104H,
  input  logic [31:0] PcPlus4Q104H,
  input  logic        DMemRspValidQ104H,
  input  logic [31:0] DMemRdDataQ104H,
  output logic        ReadyQ104H,
  output logic        RegWrEnQ105H,
  output logic [4:0]  RegDstQ105H,
  output logic [31:0] RegWrDataQ105H,
`ifdef CORE_RRV_WB_TIMEOUT_EN
  output logic        LoadTimeoutErr,
`endif
  output t_wb_state   wb_state
);

  t_wb_state   state;
  t_wb_state   state_next;
  logic        load_q104h;
  logic        timeout_hit;
  logic        timeout_fire;
  logic        wr_en_next;
  logic [31:0] ld_data;
  logic [31:0] wr_data_next;

  assign load_q104h = Ctrl.ValidQ104H && (Ctrl.WbSelQ104H == WB_MEM);
  assign wb_state   = state;

  core_rrv_wb_ld_align u_ld_align (
    .data     (DMemRdDataQ104H),
    .offset   (AluResultQ104H[1:0]),
    .byte_en  (Ctrl.ByteEnQ104H),
    .sign_ext (Ctrl.SignExtQ104H),
    .result   (ld_data)
  );

  // Reset forces Ready high because the case below is skipped entirely.
  always_comb begin
    state_next   = state;
    ReadyQ104H   = 1'b1;
    timeout_fire = 1'b0;
    if (!Rst) begin
      case (state)
        WB_IDLE: begin
          if (load_q104h && !DMemRspValidQ104H) begin
            ReadyQ104H = 1'b0;
            state_next = WB_WAIT_RSP;
          end
        end
        WB_WAIT_RSP: begin
          if (DMemRspValidQ104H) begin
            state_next = WB_IDLE;
          end else if (timeout_hit) begin
            timeout_fire = 1'b1;
            state_next   = WB_IDLE;
          end else begin
            ReadyQ104H = 1'b0;
          end
        end
        default: state_next = WB_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_data_next = AluResultQ104H;
    case (Ctrl.WbSelQ104H)
      WB_ALU:  wr_data_next = AluResultQ104H;
      WB_PC4:  wr_data_next = PcPlus4Q104H;
      WB_MEM:  wr_data_next = ld_data;
      default: wr_data_next = AluResultQ104H;
    endcase
  end

  assign wr_en_next = Ctrl.ValidQ104H && Ctrl.RegWrEnQ104H && (Ctrl.RegDstQ104H != 5'd0)
                      && ReadyQ104H && !timeout_fire;

  always_ff @(posedge Clock) begin
    if (Rst) state <= WB_IDLE;
    else     state <= state_next;
  end

  // A stalled cycle loads a bubble so each instruction writes exactly once.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      RegWrEnQ105H   <= 1'b0;
      RegDstQ105H    <= 5'd0;
      RegWrDataQ105H <= 32'd0;
    end else begin
      RegWrEnQ105H <= wr_en_next;
      if (ReadyQ104H) begin
        RegDstQ105H    <= Ctrl.RegDstQ104H;
        RegWrDataQ105H <= wr_data_next;
      end
    end
  end

`ifdef CORE_RRV_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(WB_TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == CNT_W'(WB_TIMEOUT_CYC));

  always_ff @(posedge Clock) begin
    if (Rst) begin
      wait_cnt <= '0;
    end else if (state == WB_WAIT_RSP && state_next == WB_WAIT_RSP) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst)               LoadTimeoutErr <= 1'b0;
    else if (timeout_fire) LoadTimeoutErr <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
